// File: rtl/andor_pkg.sv
// Shared opcode constants and FSM state type for the AND/OR arbiter slice.
package andor_pkg;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_OR  = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/andor_unit.sv
// Combinational W-bit bitwise unit: AND or OR of two operands, selected by op.
module andor_unit
    import andor_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         op_i,
    output logic [W-1:0] z_o
);

    assign z_o = (op_i == OP_OR) ? (x_i | y_i) : (x_i & y_i);

endmodule

// File: rtl/andor_arbiter.sv
// Round-robin arbiter sharing one AND/OR unit between NREQ requesters; the
// result is registered with the winner's ID and held on a backpressured port.
module andor_arbiter
    import andor_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ-1:0]   req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    output logic [W-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id,
    input  logic              resp_ready,
    output logic [7:0]        op_count,
    output state_e            dbg_state
);

    // Handshake: request i transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; the response transfers where resp_valid and
    // resp_ready are both high. Valid must not depend on ready.

    state_e          state_q;
    logic            resp_valid_q;
    logic [W-1:0]    resp_data_q;
    logic [IDW-1:0]  resp_id_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [7:0]      op_count_q;

    logic            can_issue;
    logic            grant_found;
    logic            accept;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand;
    logic [IDW-1:0]  rr_ptr_d;
    logic [W-1:0]    resp_data_d;
    logic [W-1:0]    x_sel;
    logic [W-1:0]    y_sel;
    logic            op_sel;

    // Reset gates issue so req_ready is zero while reset_n is held low.
    always_comb begin
        can_issue   = reset_n && ((state_q == S_IDLE) || resp_ready);
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
        accept    = can_issue && grant_found;
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end

    assign x_sel  = req_x[grant_idx*W +: W];
    assign y_sel  = req_y[grant_idx*W +: W];
    assign op_sel = req_op[grant_idx];

    andor_unit #(.W(W)) u_unit (
        .x_i  (x_sel),
        .y_i  (y_sel),
        .op_i (op_sel),
        .z_o  (resp_data_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            rr_ptr_q     <= '0;
            op_count_q   <= '0;
        end else begin
            // A new accept always wins; it can only happen in RESP when the
            // held result is being consumed in the same cycle.
            if (accept) begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                resp_data_q  <= resp_data_d;
                resp_id_q    <= grant_idx;
                rr_ptr_q     <= rr_ptr_d;
                op_count_q   <= op_count_q + 8'd1;
            end else if ((state_q == S_RESP) && resp_ready) begin
                state_q      <= S_IDLE;
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_andor_arbiter.sv
// Bench for andor_arbiter: reference model plus expected-response queue.
module tb_andor_arbiter;
    import andor_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_op;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [W-1:0]      resp_data;
    logic [IDW-1:0]    resp_id;
    logic              resp_ready;
    logic [7:0]        op_count;
    state_e            dbg_state;

    always #5 clk = ~clk;

    andor_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .op_count   (op_count),
        .dbg_state  (dbg_state)
    );

    // Requests the bench is currently presenting.
    logic            pend_v  [NREQ];
    logic [W-1:0]    pend_x  [NREQ];
    logic [W-1:0]    pend_y  [NREQ];
    logic            pend_op [NREQ];

    // Reference model state.
    int              m_rr;
    int              m_cnt;
    bit              m_hold;
    int              m_g;
    logic [NREQ-1:0] m_rdy;
    logic [W-1:0]    m_val;
    logic [NREQ-1:0] acc_mask;
    logic [IDW+W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend_v[i];
            req_x[i*W +: W]    = pend_x[i];
            req_y[i*W +: W]    = pend_y[i];
            req_op[i]          = pend_op[i];
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        pend_v[i]  = 1'b1;
        pend_x[i]  = x;
        pend_y[i]  = y;
        pend_op[i] = op;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i]  = 1'b0;
            pend_x[i]  = '0;
            pend_y[i]  = '0;
            pend_op[i] = 1'b0;
        end
    endtask

    task automatic refill_all();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_v[i]) begin
                set_req(i, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    // Advance one clock; requests the model saw granted are retired.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) pend_v[i] = 1'b0;
        end
        acc_mask = '0;
        apply();
    endtask

    // Reference model: round-robin over the presented requests, one slot per
    // cycle while nothing is held or the held result is being taken.
    always @(negedge clk) begin
        if (reset_n) begin
            m_g   = -1;
            m_rdy = '0;
            if (!m_hold || resp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_g < 0 && pend_v[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
                end
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(m_rdy));
            chk("resp_valid", 32'(resp_valid), 32'(m_hold));
            chk("op_count", 32'(op_count), m_cnt);
            if (m_g >= 0) begin
                m_val = pend_op[m_g] ? (pend_x[m_g] | pend_y[m_g]) : (pend_x[m_g] & pend_y[m_g]);
                exp_q.push_back({IDW'(m_g), m_val});
                m_rr     = (m_g + 1) % NREQ;
                m_cnt    = (m_cnt + 1) % 256;
                m_hold   = 1'b1;
                acc_mask = m_rdy;
            end else if (resp_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    // Monitor: every presented response must match the queue head.
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'(exp_q.size()), 1);
            end else begin
                chk("resp_id", 32'(resp_id), 32'(exp_q[0][IDW+W-1:W]));
                chk("resp_data", 32'(resp_data), 32'(exp_q[0][W-1:0]));
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int exp_g;
        clear_all();
        acc_mask   = '0;
        m_rr       = 0;
        m_cnt      = 0;
        m_hold     = 1'b0;
        resp_ready = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("reset_valid", 32'(resp_valid), 0);
        chk("reset_data", 32'(resp_data), 0);
        chk("reset_id", 32'(resp_id), 0);
        chk("reset_count", 32'(op_count), 0);

        // Single requester
        set_req(1, 2'b10, 2'b11, OP_AND);
        apply();
        #1;
        chk("single_grant", 32'(req_ready), 32'(4'b0010));
        step();
        #1;
        chk("single_valid", 32'(resp_valid), 1);
        chk("single_data", 32'(resp_data), 32'(2'b10));
        chk("single_id", 32'(resp_id), 1);

        // Fairness: all valid, pointer now sits at 2
        refill_all();
        apply();
        exp_g = 2;
        for (int n = 1; n <= 6; n++) begin
            #1;
            chk("fair_grant", 32'(req_ready), 32'(1) << exp_g);
            step();
            refill_all();
            apply();
            #1;
            chk("fair_count", 32'(op_count), 1 + n);
            exp_g = (exp_g + 1) % NREQ;
        end

        // Drain, then backpressure
        clear_all();
        apply();
        step();
        step();
        set_req(2, 2'b01, 2'b10, OP_OR);
        apply();
        step();
        set_req(0, 2'b11, 2'b11, OP_AND);
        resp_ready = 1'b0;
        apply();
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_data", 32'(resp_data), 32'(2'b11));
            chk("bp_id", 32'(resp_id), 2);
            chk("bp_state", 32'(dbg_state), 32'(S_RESP));
            step();
        end
        resp_ready = 1'b1;
        apply();
        #1;
        chk("bp_regrant", 32'(req_ready), 32'(4'b0001));
        step();
        #1;
        chk("bp_next_id", 32'(resp_id), 0);
        chk("bp_next_data", 32'(resp_data), 32'(2'b11));

        // Mixed opcodes
        set_req(0, 2'b11, 2'b01, OP_AND);
        apply();
        step();
        #1;
        chk("mix_data0", 32'(resp_data), 32'(2'b01));
        chk("mix_id0", 32'(resp_id), 0);
        set_req(3, 2'b00, 2'b10, OP_OR);
        apply();
        step();
        #1;
        chk("mix_data3", 32'(resp_data), 32'(2'b10));
        chk("mix_id3", 32'(resp_id), 3);

        // Reset while holding 2'b11
        clear_all();
        apply();
        step();
        step();
        set_req(2, 2'b01, 2'b10, OP_OR);
        apply();
        step();
        resp_ready = 1'b0;
        #1;
        chk("rst_pre_data", 32'(resp_data), 32'(2'b11));
        set_req(1, 2'b01, 2'b01, OP_OR);
        resp_ready = 1'b1;
        apply();
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_data", 32'(resp_data), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_count", 32'(op_count), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        clear_all();
        apply();
        exp_q.delete();
        acc_mask = '0;
        m_rr     = 0;
        m_cnt    = 0;
        m_hold   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Wrap: 256 back-to-back accepts from a fresh reset
        refill_all();
        apply();
        for (int n = 1; n <= 256; n++) begin
            step();
            refill_all();
            apply();
            #1;
            if (n == 3)   chk("wrap_rr3", 32'(req_ready), 32'(4'b1000));
            if (n == 4)   chk("wrap_rr0", 32'(req_ready), 32'(4'b0001));
            if (n == 255) chk("wrap_cnt255", 32'(op_count), 255);
            if (n == 256) chk("wrap_cnt0", 32'(op_count), 0);
        end

        // Random traffic with backpressure and early drops
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end else if ($urandom_range(0, 15) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            apply();
            step();
        end

        clear_all();
        resp_ready = 1'b1;
        apply();
        repeat (3) step();
        #1;
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
